// File: rtl/register_file_if.sv
// Bus bundle for the 8 x 16-bit register file.
// It groups the write port, both read ports, the freeze control and the
// eight display taps. The CPU/testbench side uses the master modport and
// the register file uses the slave modport.
interface register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              freeze;
  logic [DATA_W-1:0] r1, r2, r3, r4, r5, r6, r7, r8;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, freeze,
    input  rd_data_a, rd_data_b, r1, r2, r3, r4, r5, r6, r7, r8
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, freeze,
    output rd_data_a, rd_data_b, r1, r2, r3, r4, r5, r6, r7, r8
  );
endinterface

// File: rtl/register_file.sv
// Register file for the 16-bit CPU datapath: 8 x 16-bit registers.
// It has one synchronous write port and two combinational read ports.
// The read ports can optionally bypass the write data, so a register
// written this cycle is already visible on a read of the same address.
// A shadow bank lets the seven-segment taps r1..r8 show a frozen snapshot
// while the CPU keeps writing the live registers.
module register_file #(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit              BYPASS    = 1'b1
) (
  input logic            clock,
  input logic            reset,
  register_file_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs      [NREGS];
  logic [DATA_W-1:0] shadow    [NREGS];
  logic [DATA_W-1:0] next_regs [NREGS];
  logic [DATA_W-1:0] taps      [NREGS];

  // Compute what the live bank holds after this edge. The shadow loads the
  // same value, so a write made while the bank is unfrozen reaches the taps at once.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      next_regs[i] = regs[i];
    end
    if (bus.wr_en) begin
      next_regs[bus.wr_addr] = bus.wr_data;
    end
  end

  // Update the live and shadow banks. Reset wins over writes and freeze.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i]   <= RESET_VAL;
        shadow[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= next_regs[i];
        if (!bus.freeze) begin
          shadow[i] <= next_regs[i];
        end
      end
    end
  end

  // Operand fetch for port A. Write-through applies when BYPASS is set.
  always_comb begin
    if (BYPASS && bus.wr_en && (bus.rd_addr_a == bus.wr_addr)) begin
      bus.rd_data_a = bus.wr_data;
    end else begin
      bus.rd_data_a = regs[bus.rd_addr_a];
    end
  end

  // Operand fetch for port B. It mirrors port A.
  always_comb begin
    if (BYPASS && bus.wr_en && (bus.rd_addr_b == bus.wr_addr)) begin
      bus.rd_data_b = bus.wr_data;
    end else begin
      bus.rd_data_b = regs[bus.rd_addr_b];
    end
  end

  // Display mux. While frozen it shows the snapshot, otherwise the live bank.
  // The shadow equals the live bank whenever the file is unfrozen, so
  // raising freeze never changes what the taps show.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      taps[i] = bus.freeze ? shadow[i] : regs[i];
    end
  end

  assign bus.r1 = taps[0];
  assign bus.r2 = taps[1];
  assign bus.r3 = taps[2];
  assign bus.r4 = taps[3];
  assign bus.r5 = taps[4];
  assign bus.r6 = taps[5];
  assign bus.r7 = taps[6];
  assign bus.r8 = taps[7];
endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file. It builds one instance with write-through
// enabled and one without, and drives both with identical stimulus. An
// array-based model predicts every output, and the predictions are queued
// for a monitor that checks them on the falling clock edge.
module tb_register_file;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef struct {
    logic [15:0]      a_byp;
    logic [15:0]      a_raw;
    logic [15:0]      b_byp;
    logic [15:0]      b_raw;
    logic [7:0][15:0] taps;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_byp ();
  register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_raw ();

  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_VAL(16'h0), .BYPASS(1'b1))
    dut_byp (.clock(clock), .reset(reset), .bus(bus_byp));
  register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_VAL(16'h0), .BYPASS(1'b0))
    dut_raw (.clock(clock), .reset(reset), .bus(bus_raw));

  logic [15:0] m_regs   [8];
  logic [15:0] m_shadow [8];
  exp_t        expq [$];
  int          tests  = 0;
  int          failed = 0;
  logic        frz_state;

  // Free-running 100 MHz clock
  always #5 clock = ~clock;

  // Compare one observed value with the expected value and record the result
  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Advance the model across one rising edge using the inputs that were applied
  task automatic updateModel();
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i]   = 16'h0;
        m_shadow[i] = 16'h0;
      end
    end else begin
      if (bus_byp.wr_en) m_regs[bus_byp.wr_addr] = bus_byp.wr_data;
      if (!bus_byp.freeze) begin
        for (int i = 0; i < 8; i++) m_shadow[i] = m_regs[i];
      end
    end
  endtask

  // Apply one cycle of inputs to both instances and queue the expected outputs
  task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] wa,
                               input logic [15:0] wd, input logic [2:0] ra,
                               input logic [2:0] rb, input logic frz);
    exp_t e;
    @(posedge clock);
    updateModel();
    #1;
    reset = rst;
    bus_byp.wr_en = we;  bus_raw.wr_en = we;
    bus_byp.wr_addr = wa; bus_raw.wr_addr = wa;
    bus_byp.wr_data = wd; bus_raw.wr_data = wd;
    bus_byp.rd_addr_a = ra; bus_raw.rd_addr_a = ra;
    bus_byp.rd_addr_b = rb; bus_raw.rd_addr_b = rb;
    bus_byp.freeze = frz; bus_raw.freeze = frz;
    e.a_raw = m_regs[ra];
    e.b_raw = m_regs[rb];
    e.a_byp = (we && wa == ra) ? wd : m_regs[ra];
    e.b_byp = (we && wa == rb) ? wd : m_regs[rb];
    for (int i = 0; i < 8; i++) e.taps[i] = frz ? m_shadow[i] : m_regs[i];
    expq.push_back(e);
  endtask

  // Monitor: compare every queued prediction with both instances' outputs
  always @(negedge clock) begin
    while (expq.size() != 0) begin
      exp_t e;
      logic [7:0][15:0] got_b, got_r;
      e = expq.pop_front();
      got_b = {bus_byp.r8, bus_byp.r7, bus_byp.r6, bus_byp.r5,
               bus_byp.r4, bus_byp.r3, bus_byp.r2, bus_byp.r1};
      got_r = {bus_raw.r8, bus_raw.r7, bus_raw.r6, bus_raw.r5,
               bus_raw.r4, bus_raw.r3, bus_raw.r2, bus_raw.r1};
      checkOutput("byp_rd_a", bus_byp.rd_data_a, e.a_byp);
      checkOutput("byp_rd_b", bus_byp.rd_data_b, e.b_byp);
      checkOutput("raw_rd_a", bus_raw.rd_data_a, e.a_raw);
      checkOutput("raw_rd_b", bus_raw.rd_data_b, e.b_raw);
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("byp_r%0d", i + 1), got_b[i], e.taps[i]);
        checkOutput($sformatf("raw_r%0d", i + 1), got_r[i], e.taps[i]);
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed cases first, then randomized traffic
  initial begin
    for (int i = 0; i < 8; i++) begin
      m_regs[i]   = 16'h0;
      m_shadow[i] = 16'h0;
    end
    reset = 1'b1;
    bus_byp.wr_en = 1'b0; bus_raw.wr_en = 1'b0;
    bus_byp.wr_addr = 3'd0; bus_raw.wr_addr = 3'd0;
    bus_byp.wr_data = 16'h0; bus_raw.wr_data = 16'h0;
    bus_byp.rd_addr_a = 3'd0; bus_raw.rd_addr_a = 3'd0;
    bus_byp.rd_addr_b = 3'd0; bus_raw.rd_addr_b = 3'd0;
    bus_byp.freeze = 1'b0; bus_raw.freeze = 1'b0;

    // Reset: everything reads zero afterwards
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd3, 3'd6, 0);
    // Write/read of BEEF at address 5
    applyStimulus(0, 1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 0);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd5, 3'd4, 0);
    // Bypass on port B at address 2
    applyStimulus(0, 1, 3'd2, 16'h1234, 3'd1, 3'd2, 0);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd2, 3'd2, 0);
    // Freeze: AA visible on the taps, BB only on the read ports
    applyStimulus(0, 1, 3'd0, 16'h00AA, 3'd0, 3'd0, 0);
    applyStimulus(0, 1, 3'd0, 16'h00BB, 3'd0, 3'd0, 1);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd0, 3'd0, 1);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd0, 3'd0, 0);
    // Reset priority during freeze, with a simultaneous write to address 7
    applyStimulus(0, 1, 3'd7, 16'h5555, 3'd7, 3'd7, 0);
    applyStimulus(0, 1, 3'd7, 16'h6666, 3'd7, 3'd0, 1);
    applyStimulus(1, 1, 3'd7, 16'hFFFF, 3'd7, 3'd6, 1);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd7, 3'd7, 1);
    applyStimulus(0, 0, 3'd0, 16'h0, 3'd7, 3'd7, 0);
    // Sweep: back-to-back writes, then read every address on both ports
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 1, 3'(i), 16'(16'h1111 * (i + 1)), 3'(i), 3'(7 - i), 0);
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 0);

    // Randomized traffic with occasional resets and toggling freeze
    frz_state = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) frz_state = ~frz_state;
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 16'($urandom),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), frz_state);
    end

    @(negedge clock);
    #1;
    tests++;
    if (expq.size() != 0) begin
      failed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
